cache_tag_ctrl: RTL

- Parametrised set-associative tag controller for the CPU cache.
- Holds tag, valid and LRU state per set, and accepts lookups through a valid/ready handshake.
- Returns hit or miss, the hit or victim way, and runs a refill handshake toward memory on a miss.
- Sits between the CPU load/store path and the data-array and memory interface; supports a whole-cache flush.

---
 rtl/cache_pkg.sv | 52 +++++
 rtl/cache_tag_way.sv | 66 ++++++
 rtl/cache_tag_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared definitions for the cache tag controller. It holds the
//             FSM state encoding, the helpers that derive the tag width and
//             set count, and an address splitter that returns index and tag.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CMP    = 2'd1,
      ST_REFILL = 2'd2
   } state_t;

   // Default geometry of the CPU cache
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_OFFSET_W = 2;
   localparam int DEF_INDEX_W  = 4;

   function automatic int tag_width(input int addr_w, input int offset_w,
                                    input int index_w);
      return addr_w - index_w - offset_w;
   endfunction

   function automatic int set_count(input int index_w);
      return 1 << index_w;
   endfunction

   localparam int DEF_TAG_W = tag_width(DEF_ADDR_W, DEF_OFFSET_W, DEF_INDEX_W);
   localparam int DEF_SETS  = set_count(DEF_INDEX_W);

   // Index and tag are returned zero-extended to 32 bits; callers size-cast
   // them down to INDEX_W / TAG_W. Addresses are limited to 32 bits.
   typedef struct packed {
      logic [31:0] index;
      logic [31:0] tag;
   } addr_split_t;

   function automatic addr_split_t split_addr(input logic [31:0] add,
                                              input int offset_w,
                                              input int index_w);
      addr_split_t s;
      s.index = (add >> offset_w) & ((32'd1 << index_w) - 32'd1);
      s.tag   = add >> (offset_w + index_w);
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_way.sv
`default_nettype none
// ============================================================================
//  Module   : cache_tag_way
//  Purpose  : One way of the tag store: a tag array (not reset) plus a
//             valid bit per set, with single-set write, clear-all and a
//             tag-match output for the currently addressed set.
//  Ports    : clk, rst        clock, synchronous active-high reset
//             clear_all       invalidate every set
//             wr_en, wr_tag   write wr_tag into set 'index' and mark valid
//             index           set being compared / written
//             cmp_tag         tag to compare against the stored one
//             match           stored line valid and tag equal
//             valid           valid bit of set 'index'
//  Revision : 1.0  initial release
// ============================================================================
module cache_tag_way
   import cache_pkg::*;
#(
   parameter int INDEX_W = DEF_INDEX_W,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_all,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [TAG_W-1:0]   cmp_tag,
   output logic               match,
   output logic               valid
);
   localparam int SETS = set_count(INDEX_W);

   logic [TAG_W-1:0] tag_mem [SETS];
   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  valid_d;

   always_comb begin
      valid_d = valid_q;
      if (clear_all) begin
         valid_d = '0;
      end else if (wr_en) begin
         valid_d[index] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tags need no reset: a tag is only ever looked at behind its valid bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[index] <= wr_tag;
      end
   end

   assign valid = valid_q[index];
   assign match = valid_q[index] & (tag_mem[index] == cmp_tag);

endmodule
`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_tag_ctrl
//  Purpose  : Set-associative (1 or 2 way) tag controller. Accepts lookups
//             on a valid/ready handshake, answers hit/miss with the hit or
//             filled way, runs a refill handshake on a miss and supports a
//             whole-cache flush.
//  Ports    : clk, rst                clock, synchronous active-high reset
//             req_valid/req_ready     lookup handshake
//             req_add                 lookup byte address
//             flush                   invalidate all lines (IDLE only)
//             resp_valid/hit/way      one-cycle response strobe and payload
//             refill_req/refill_add   line fetch request toward memory
//             refill_ack              memory delivered the line
//  Revision : 1.0  initial release
// ============================================================================
module cache_tag_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int WAYS     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_add,
   input  logic              flush,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic              resp_way,
   output logic              refill_req,
   output logic [ADDR_W-1:0] refill_add,
   input  logic              refill_ack
);
   localparam int TAG_W = tag_width(ADDR_W, OFFSET_W, INDEX_W);
   localparam int SETS  = set_count(INDEX_W);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] add_q, add_d;
   logic              victim_q, victim_d;
   logic [SETS-1:0]   lru_q, lru_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_hit_q, resp_hit_d;
   logic              resp_way_q, resp_way_d;
   logic              refill_req_q, refill_req_d;
   logic [ADDR_W-1:0] refill_add_q, refill_add_d;

   // Lookups and fills always work on the latched request address.
   addr_split_t        w_split;
   logic [INDEX_W-1:0] w_index;
   logic [TAG_W-1:0]   w_tag;

   assign w_split = split_addr(32'(add_q), OFFSET_W, INDEX_W);
   assign w_index = INDEX_W'(w_split.index);
   assign w_tag   = TAG_W'(w_split.tag);

   logic [WAYS-1:0] w_match;
   logic [WAYS-1:0] w_valid;
   logic [WAYS-1:0] w_wr_en;
   logic            w_fill;
   logic            w_clear;
   logic            w_hit;
   logic            w_hit_way;
   logic            w_victim;

   assign w_fill  = (state_q == ST_REFILL) & refill_ack;
   assign w_clear = (state_q == ST_IDLE) & flush;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign w_wr_en[g] = w_fill & (victim_q == 1'(g));

      cache_tag_way #(
         .INDEX_W (INDEX_W),
         .TAG_W   (TAG_W)
      ) u_way (
         .clk       (clk),
         .rst       (rst),
         .clear_all (w_clear),
         .wr_en     (w_wr_en[g]),
         .index     (w_index),
         .wr_tag    (w_tag),
         .cmp_tag   (w_tag),
         .match     (w_match[g]),
         .valid     (w_valid[g])
      );
   end

   if (WAYS == 2) begin : g_two_way
      assign w_hit     = |w_match;
      assign w_hit_way = w_match[1] & ~w_match[0];
      // Fill an empty way first (way 0 before way 1), else evict by LRU.
      assign w_victim  = ~w_valid[0] ? 1'b0 :
                         ~w_valid[1] ? 1'b1 : lru_q[w_index];
   end else if (WAYS == 1) begin : g_one_way
      assign w_hit     = w_match[0];
      assign w_hit_way = 1'b0;
      assign w_victim  = 1'b0;
   end else begin : g_bad_ways
      $error("cache_tag_ctrl: WAYS must be 1 or 2");
   end

   always_comb begin
      state_d      = state_q;
      add_d        = add_q;
      victim_d     = victim_q;
      lru_d        = lru_q;
      resp_valid_d = 1'b0;
      resp_hit_d   = 1'b0;
      resp_way_d   = 1'b0;
      refill_req_d = refill_req_q;
      refill_add_d = refill_add_q;
      req_ready    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = ~flush;
            if (flush) begin
               lru_d = '0;
            end else if (req_valid) begin
               add_d   = req_add;
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            if (w_hit) begin
               resp_valid_d   = 1'b1;
               resp_hit_d     = 1'b1;
               resp_way_d     = w_hit_way;
               lru_d[w_index] = ~w_hit_way;
               state_d        = ST_IDLE;
            end else begin
               refill_req_d = 1'b1;
               refill_add_d = {add_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               victim_d     = w_victim;
               state_d      = ST_REFILL;
            end
         end
         ST_REFILL: begin
            if (refill_ack) begin
               refill_req_d   = 1'b0;
               resp_valid_d   = 1'b1;
               resp_way_d     = victim_q;
               lru_d[w_index] = ~victim_q;
               state_d        = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         add_q        <= '0;
         victim_q     <= 1'b0;
         lru_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_way_q   <= 1'b0;
         refill_req_q <= 1'b0;
         refill_add_q <= '0;
      end else begin
         state_q      <= state_d;
         add_q        <= add_d;
         victim_q     <= victim_d;
         lru_q        <= lru_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_way_q   <= resp_way_d;
         refill_req_q <= refill_req_d;
         refill_add_q <= refill_add_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign resp_way   = resp_way_q;
   assign refill_req = refill_req_q;
   assign refill_add = refill_add_q;

endmodule
`default_nettype wire
